// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main controller.
// Holds the 4-bit state enum, opcode constants and datapath select encodings.
// Imported by mc_ctrl_outdec and mc_main_ctrl.
package mc_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC_R = 4'd7,
    ST_R_WB   = 4'd8,
    ST_EXEC_I = 4'd9,
    ST_I_WB   = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b110;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decoder: state (+latched opcode, mem ready) -> datapath controls.
// Zero latency; FETCH write strobes are qualified by mem_ready so a stalled fetch never loads IR/PC.
// Every non-listed state (RST, TRAP) decodes to an all-zero control word.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]         state,
  input  logic [OP_W-1:0]    op_q,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op
);

  logic [ALUOP_W-1:0] imm_alu_op;

  // Immediate ops: slti needs set-less-than, everything else in this class adds.
  always_comb begin
    imm_alu_op = (op_q == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
  end

  // Moore decode of the control word; defaults are the safe all-zero word.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_RTYPE;
    case (state_t'(state))
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        pc_source = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = imm_alu_op;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing from the IR opcode.
// beq/j 3, R/addi/slti/sw 4, lw 5 cycles; each cycle without mem_ready in FETCH/MEMRD/MEMWR adds one.
// Macro MC_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP with illegal_o high; otherwise they act as a NOP.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [OP_W-1:0]    opcode_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               mem_to_reg_o,
  output logic               reg_dst_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         pc_source_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [3:0]         state_o
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic               illegal_o
`endif
);

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op_q;

  // State register; reset drops straight to RST so the decoder zeroes all strobes at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the opcode in DECODE so later states do not depend on the IR staying stable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q <= '0;
    end else if (state_q == ST_DECODE) begin
      op_q <= opcode_i;
    end
  end

  // Next-state logic; memory states hold until the shared ready arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH:  state_d = mem_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode_i)
          OP_RTYPE:         state_d = ST_EXEC_R;
          OP_LW, OP_SW:     state_d = ST_MEMADR;
          OP_ADDI, OP_SLTI: state_d = ST_EXEC_I;
          OP_BEQ:           state_d = ST_BRANCH;
          OP_J:             state_d = ST_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:          state_d = ST_TRAP;
`else
          default:          state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR: state_d = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = mem_ready_i ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  state_d = mem_ready_i ? ST_FETCH : ST_MEMWR;
      ST_EXEC_R: state_d = ST_R_WB;
      ST_R_WB:   state_d = ST_FETCH;
      ST_EXEC_I: state_d = ST_I_WB;
      ST_I_WB:   state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      ST_TRAP:   state_d = ST_TRAP;
`else
      ST_TRAP:   state_d = ST_FETCH;
`endif
      default:   state_d = ST_RST;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state         (state_q),
    .op_q          (op_q),
    .mem_ready     (mem_ready_i),
    .pc_write      (pc_write_o),
    .pc_write_cond (pc_write_cond_o),
    .iord          (iord_o),
    .mem_read      (mem_read_o),
    .mem_write     (mem_write_o),
    .ir_write      (ir_write_o),
    .mem_to_reg    (mem_to_reg_o),
    .reg_dst       (reg_dst_o),
    .reg_write     (reg_write_o),
    .alu_src_a     (alu_src_a_o),
    .alu_src_b     (alu_src_b_o),
    .pc_source     (pc_source_o),
    .alu_op        (alu_op_o)
  );

  assign state_o = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_o = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: steps each instruction class cycle by cycle.
// Expected control words are hand-built per state; write-strobe exclusion is checked every cycle.
// Covers reset, stalls in FETCH/MEMRD, reset during MEMWR, and unknown-opcode handling.
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_main_ctrl dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .opcode_i        (opcode),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .iord_o          (iord),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .ir_write_o      (ir_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .pc_source_o     (pc_source),
    .alu_op_o        (alu_op),
    .state_o         (state)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .illegal_o       (illegal)
`endif
  );

  // Observed control word, packed in a fixed field order.
  logic [20:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                alu_op, state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] cv(
    input logic pcw, input logic pcwc, input logic io, input logic mrd, input logic mwr,
    input logic irw, input logic m2r, input logic rdst, input logic rw, input logic sa,
    input logic [1:0] sb, input logic [1:0] pcs, input logic [2:0] aop, input logic [3:0] st);
    return {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, sb, pcs, aop, st};
  endfunction

  // One clock step: drive inputs after the falling edge, then sample the Moore outputs.
  task automatic stp(input string tag, input logic rdy, input logic [5:0] op, input logic [20:0] expv);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    #1;
    check(tag, {11'd0, obs}, {11'd0, expv});
  endtask

  // Write strobes must never collide, in any cycle.
  always @(negedge clk) begin
    check("excl", {30'd0, mem_write & reg_write, mem_read & mem_write}, 32'd0);
  end

  logic [20:0] zero_w, f1, f0, dec, madr, mrd_w, mwb, mwr_w, exr, rwb;
  logic [20:0] exi_add, iwb_add, exi_slt, iwb_slt, brn, jmp, trp;

  initial begin
    zero_w  = cv(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,4'd0);
    f1      = cv(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b010,4'd1);
    f0      = cv(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,4'd1);
    dec     = cv(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,4'd2);
    madr    = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,4'd3);
    mrd_w   = cv(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,4'd4);
    mwb     = cv(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,4'd5);
    mwr_w   = cv(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,4'd6);
    exr     = cv(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,4'd7);
    rwb     = cv(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,4'd8);
    exi_add = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,4'd9);
    iwb_add = cv(0,0,0,0,0,0,0,0,1,1,2'b10,2'b00,3'b010,4'd10);
    exi_slt = cv(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b111,4'd9);
    iwb_slt = cv(0,0,0,0,0,0,0,0,1,1,2'b10,2'b00,3'b111,4'd10);
    brn     = cv(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,4'd11);
    jmp     = cv(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,4'd12);
    trp     = cv(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,4'd13);

    // Reset asserted asynchronously, before any clock edge.
    #1 rst_n = 1'b0;
    #2 check("reset", {11'd0, obs}, {11'd0, zero_w});
    @(negedge clk);
    rst_n = 1'b1;

    // add: FETCH, DECODE, EXEC_R, R_WB
    stp("add_fetch", 1'b1, 6'b000000, f1);
    stp("add_dec",   1'b1, 6'b000000, dec);
    stp("add_exec",  1'b1, 6'b000000, exr);
    stp("add_wb",    1'b1, 6'b000000, rwb);

    // lw with a stalled fetch and three stall cycles in MEMRD
    stp("lw_fstall", 1'b0, 6'b100011, f0);
    stp("lw_fetch",  1'b1, 6'b100011, f1);
    stp("lw_dec",    1'b1, 6'b100011, dec);
    stp("lw_madr",   1'b1, 6'b100011, madr);
    stp("lw_rd0",    1'b0, 6'b100011, mrd_w);
    stp("lw_rd1",    1'b0, 6'b100011, mrd_w);
    stp("lw_rd2",    1'b0, 6'b100011, mrd_w);
    stp("lw_rd3",    1'b1, 6'b100011, mrd_w);
    stp("lw_wb",     1'b1, 6'b100011, mwb);

    // beq: 3 cycles
    stp("beq_fetch", 1'b1, 6'b000100, f1);
    stp("beq_dec",   1'b1, 6'b000100, dec);
    stp("beq_br",    1'b1, 6'b000100, brn);

    // slti and addi: EXEC_I ALUOp follows the captured opcode through I_WB
    stp("slti_fetch", 1'b1, 6'b001010, f1);
    stp("slti_dec",   1'b1, 6'b001010, dec);
    stp("slti_exec",  1'b1, 6'b000000, exi_slt);
    stp("slti_wb",    1'b1, 6'b000000, iwb_slt);
    stp("addi_fetch", 1'b1, 6'b001000, f1);
    stp("addi_dec",   1'b1, 6'b001000, dec);
    stp("addi_exec",  1'b1, 6'b000000, exi_add);
    stp("addi_wb",    1'b1, 6'b000000, iwb_add);

    // j: 3 cycles
    stp("j_fetch", 1'b1, 6'b000010, f1);
    stp("j_dec",   1'b1, 6'b000010, dec);
    stp("j_jump",  1'b1, 6'b000010, jmp);

    // sw, then reset pulsed while MEMWR is stalled
    stp("sw_fetch", 1'b1, 6'b101011, f1);
    stp("sw_dec",   1'b1, 6'b101011, dec);
    stp("sw_madr",  1'b1, 6'b101011, madr);
    stp("sw_wr",    1'b0, 6'b101011, mwr_w);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {11'd0, obs}, {11'd0, zero_w});
    stp("rst_hold", 1'b1, 6'b101011, zero_w);
    rst_n = 1'b1;
    stp("rst_fetch", 1'b1, 6'b000000, f1);

    // sw to completion after reset, 4 cycles
    stp("sw2_dec",  1'b1, 6'b101011, dec);
    stp("sw2_madr", 1'b1, 6'b101011, madr);
    stp("sw2_wr",   1'b1, 6'b101011, mwr_w);

    // unknown opcode 111111
    stp("ill_fetch", 1'b1, 6'b111111, f1);
    stp("ill_dec",   1'b1, 6'b111111, dec);
`ifdef MC_ILLEGAL_TRAP_EN
    stp("ill_trap0", 1'b1, 6'b000000, trp);
    check("ill_flag0", {31'd0, illegal}, 32'd1);
    stp("ill_trap1", 1'b1, 6'b000000, trp);
    check("ill_flag1", {31'd0, illegal}, 32'd1);
`else
    stp("ill_nop_fetch", 1'b1, 6'b000000, f1);
    check("ill_trap_unused", {28'd0, trp[3:0]}, 32'd13);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
